// File: rtl/pipe_phy_msg_responder.sv
// PIPE message-bus responder: decodes MAC requests, holds NUM_REGS 8-bit PHY registers,
// buffers uncommitted writes and applies them atomically on a committed write.
module pipe_phy_msg_responder #(
    parameter int NUM_REGS   = 8,
    parameter int PEND_DEPTH = 4
) (
    input  logic                  PCLK,
    input  logic                  Reset,
    input  logic [7:0]            M2P_MessageBus,
    output logic [7:0]            P2M_MessageBus,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]   reg_update,
    output logic                  pend_overflow
);

    localparam int CNT_W = $clog2(PEND_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
    typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_WR_UNC = 2'd1, CMD_WR_COM = 2'd2, CMD_RD = 2'd3} cmd_t;

    state_t state, state_next;
    cmd_t   cmd_q, cmd_next;
    logic [3:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;

    logic [7:0]  regs      [NUM_REGS];
    logic [7:0]  regs_next [NUM_REGS];
    logic [NUM_REGS-1:0] upd_next;

    logic [11:0] pend_addr [PEND_DEPTH];
    logic [7:0]  pend_data [PEND_DEPTH];
    logic [CNT_W-1:0] pend_cnt;

    logic       rd_fire, unc_fire, com_fire;
    logic       rd_pend;
    logic [7:0] rd_data, rd_val;

    assign rd_addr  = {addr_hi, M2P_MessageBus};
    assign wr_addr  = {addr_hi, addr_lo};
    assign rd_fire  = (state == S_ADDR) && (cmd_q == CMD_RD);
    assign unc_fire = (state == S_DATA) && (cmd_q == CMD_WR_UNC);
    assign com_fire = (state == S_DATA) && (cmd_q == CMD_WR_COM);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            cmd_q   <= CMD_NOP;
            addr_hi <= '0;
            addr_lo <= '0;
        end else begin
            state <= state_next;
            cmd_q <= cmd_next;
            if (state == S_IDLE) addr_hi <= M2P_MessageBus[3:0];
            if (state == S_ADDR) addr_lo <= M2P_MessageBus;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        case (state)
            S_IDLE: begin
                case (M2P_MessageBus[7:4])
                    4'h1, 4'h2, 4'h3: begin
                        cmd_next   = cmd_t'(M2P_MessageBus[5:4]);
                        state_next = S_ADDR;
                    end
                    default: ;
                endcase
            end
            S_ADDR:  state_next = (cmd_q == CMD_RD) ? S_IDLE : S_DATA;
            S_DATA:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Out-of-range addresses never match a register index, so they read 0 and are dropped on commit.
    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (rd_addr == 12'(r)) rd_val = regs[r];
    end

    always_comb begin
        regs_next = regs;
        upd_next  = '0;
        if (com_fire) begin
            for (int p = 0; p < PEND_DEPTH; p++)
                if (CNT_W'(p) < pend_cnt)
                    for (int r = 0; r < NUM_REGS; r++)
                        if (pend_addr[p] == 12'(r)) begin
                            regs_next[r] = pend_data[p];
                            upd_next[r]  = 1'b1;
                        end
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_addr == 12'(r)) begin
                    regs_next[r] = M2P_MessageBus;
                    upd_next[r]  = 1'b1;
                end
        end
    end

    always_ff @(posedge PCLK) begin
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            reg_update <= '0;
        end else begin
            regs       <= regs_next;
            reg_update <= upd_next;
        end
    end

    always_ff @(posedge PCLK) begin
        if (Reset) begin
            pend_cnt      <= '0;
            pend_overflow <= 1'b0;
        end else if (com_fire) begin
            pend_cnt <= '0;
        end else if (unc_fire) begin
            if (pend_cnt < CNT_W'(PEND_DEPTH)) pend_cnt <= pend_cnt + 1'b1;
            else                               pend_overflow <= 1'b1;
        end
    end

    // NOTE: buffer storage is not reset; pend_cnt alone decides which entries are live.
    always_ff @(posedge PCLK) begin
        if (!Reset && unc_fire && pend_cnt < CNT_W'(PEND_DEPTH)) begin
            for (int p = 0; p < PEND_DEPTH; p++)
                if (CNT_W'(p) == pend_cnt) begin
                    pend_addr[p] <= wr_addr;
                    pend_data[p] <= M2P_MessageBus;
                end
        end
    end

    // Fixed response latency means a new header never lands on a pending read-data cycle.
    always_ff @(posedge PCLK) begin
        if (Reset) begin
            P2M_MessageBus <= 8'h00;
            rd_pend        <= 1'b0;
            rd_data        <= '0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_fire) rd_data <= rd_val;
            if (rd_fire)       P2M_MessageBus <= 8'h40;
            else if (com_fire) P2M_MessageBus <= 8'h50;
            else if (rd_pend)  P2M_MessageBus <= rd_data;
            else               P2M_MessageBus <= 8'h00;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_pipe_phy_msg_responder.sv
// Directed bench for pipe_phy_msg_responder: each task drives a scenario and checks
// hand-computed P2M, reg_q, reg_update and pend_overflow values.
module tb_pipe_phy_msg_responder;

    logic        PCLK = 1'b0;
    logic        Reset;
    logic [7:0]  M2P_MessageBus;
    logic [7:0]  P2M_MessageBus;
    logic [63:0] reg_q;
    logic [7:0]  reg_update;
    logic        pend_overflow;

    int total = 0;
    int bad   = 0;

    pipe_phy_msg_responder #(.NUM_REGS(8), .PEND_DEPTH(4)) dut (
        .PCLK          (PCLK),
        .Reset         (Reset),
        .M2P_MessageBus(M2P_MessageBus),
        .P2M_MessageBus(P2M_MessageBus),
        .reg_q         (reg_q),
        .reg_update    (reg_update),
        .pend_overflow (pend_overflow)
    );

    always #5 PCLK = ~PCLK;

    // Present one byte for one clock; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [7:0] b);
        M2P_MessageBus = b;
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        M2P_MessageBus = 8'h00;
        repeat (2) @(posedge PCLK);
        #1;
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL reset_p2m: got %h want 00", P2M_MessageBus); end
        total++; if (reg_q !== 64'h0) begin bad++; $display("FAIL reset_regq: got %h want 0", reg_q); end
        total++; if (reg_update !== 8'h00) begin bad++; $display("FAIL reset_upd: got %b want 0", reg_update); end
        total++; if (pend_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", pend_overflow); end
        Reset = 1'b0;
    endtask

    task automatic test_commit_read();
        send(8'h20); send(8'h03); send(8'hA5);
        total++; if (P2M_MessageBus !== 8'h50) begin bad++; $display("FAIL cr_ack: got %h want 50", P2M_MessageBus); end
        total++; if (reg_update !== 8'b0000_1000) begin bad++; $display("FAIL cr_upd: got %b want 00001000", reg_update); end
        total++; if (reg_q[31:24] !== 8'hA5) begin bad++; $display("FAIL cr_reg3: got %h want a5", reg_q[31:24]); end
        send(8'h30);
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL cr_ack_len: got %h want 00", P2M_MessageBus); end
        total++; if (reg_update !== 8'h00) begin bad++; $display("FAIL cr_upd_len: got %b want 0", reg_update); end
        send(8'h03);
        total++; if (P2M_MessageBus !== 8'h40) begin bad++; $display("FAIL cr_rd_hdr: got %h want 40", P2M_MessageBus); end
        send(8'h00);
        total++; if (P2M_MessageBus !== 8'hA5) begin bad++; $display("FAIL cr_rd_data: got %h want a5", P2M_MessageBus); end
        send(8'h00);
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL cr_idle: got %h want 00", P2M_MessageBus); end
    endtask

    task automatic test_ordering();
        send(8'h10); send(8'h01); send(8'h11);
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL ord_noresp1: got %h want 00", P2M_MessageBus); end
        send(8'h10); send(8'h01); send(8'h22);
        total++; if (reg_q[15:8] !== 8'h00) begin bad++; $display("FAIL ord_hidden: got %h want 00", reg_q[15:8]); end
        send(8'h20); send(8'h02); send(8'h33);
        total++; if (P2M_MessageBus !== 8'h50) begin bad++; $display("FAIL ord_ack: got %h want 50", P2M_MessageBus); end
        total++; if (reg_update !== 8'b0000_0110) begin bad++; $display("FAIL ord_upd: got %b want 00000110", reg_update); end
        total++; if (reg_q !== 64'h00000000_A5332200) begin bad++; $display("FAIL ord_regs: got %h want 00000000a5332200", reg_q); end
        send(8'h00);
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL ord_one_ack: got %h want 00", P2M_MessageBus); end
    endtask

    task automatic test_overflow();
        logic [7:0] addrs [5] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
        logic [7:0] datas [5] = '{8'h44, 8'h55, 8'h66, 8'h77, 8'hEE};
        for (int i = 0; i < 5; i++) begin
            send(8'h10); send(addrs[i]); send(datas[i]);
            if (i == 3) begin
                total++; if (pend_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", pend_overflow); end
            end
        end
        total++; if (pend_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", pend_overflow); end
        send(8'h20); send(8'h01); send(8'h99);
        total++; if (reg_update !== 8'b1111_0010) begin bad++; $display("FAIL ovf_upd: got %b want 11110010", reg_update); end
        total++; if (reg_q !== 64'h77665544_A5339900) begin bad++; $display("FAIL ovf_regs: got %h want 77665544a5339900", reg_q); end
        total++; if (pend_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", pend_overflow); end
    endtask

    task automatic test_invalid();
        send(8'h31); send(8'h00);
        total++; if (P2M_MessageBus !== 8'h40) begin bad++; $display("FAIL inv_rd_hdr: got %h want 40", P2M_MessageBus); end
        send(8'h00);
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL inv_rd_data: got %h want 00", P2M_MessageBus); end
        send(8'h20); send(8'h08); send(8'h5A);
        total++; if (P2M_MessageBus !== 8'h50) begin bad++; $display("FAIL inv_ack: got %h want 50", P2M_MessageBus); end
        total++; if (reg_update !== 8'h00) begin bad++; $display("FAIL inv_upd: got %b want 0", reg_update); end
        total++; if (reg_q !== 64'h77665544_A5339900) begin bad++; $display("FAIL inv_regs: got %h want 77665544a5339900", reg_q); end
        send(8'h21); send(8'h00); send(8'hC3);
        total++; if (reg_update !== 8'h00) begin bad++; $display("FAIL inv_hi_upd: got %b want 0", reg_update); end
        total++; if (reg_q[7:0] !== 8'h00) begin bad++; $display("FAIL inv_hi_reg0: got %h want 00", reg_q[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stim [8] = '{8'h30, 8'h00, 8'h30, 8'h01, 8'h20, 8'h00, 8'hBB, 8'h00};
        logic [7:0] want [8] = '{8'h00, 8'h40, 8'h00, 8'h40, 8'h99, 8'h00, 8'h50, 8'h00};
        for (int i = 0; i < 8; i++) begin
            send(stim[i]);
            total++;
            if (P2M_MessageBus !== want[i]) begin
                bad++; $display("FAIL b2b_p2m[%0d]: got %h want %h", i, P2M_MessageBus, want[i]);
            end
        end
        total++; if (reg_q[7:0] !== 8'hBB) begin bad++; $display("FAIL b2b_reg0: got %h want bb", reg_q[7:0]); end
    endtask

    task automatic test_reset_mid();
        send(8'h10); send(8'h03); send(8'h44);
        send(8'h20); send(8'h02);
        M2P_MessageBus = 8'h77;
        Reset = 1'b1;
        @(posedge PCLK);
        #1;
        total++; if (P2M_MessageBus !== 8'h00) begin bad++; $display("FAIL rm_noack: got %h want 00", P2M_MessageBus); end
        total++; if (reg_q !== 64'h0) begin bad++; $display("FAIL rm_regs: got %h want 0", reg_q); end
        total++; if (reg_update !== 8'h00) begin bad++; $display("FAIL rm_upd: got %b want 0", reg_update); end
        total++; if (pend_overflow !== 1'b0) begin bad++; $display("FAIL rm_ovf: got %b want 0", pend_overflow); end
        Reset = 1'b0;
        send(8'h20); send(8'h00); send(8'h12);
        total++; if (P2M_MessageBus !== 8'h50) begin bad++; $display("FAIL rm_post_ack: got %h want 50", P2M_MessageBus); end
        total++; if (reg_update !== 8'b0000_0001) begin bad++; $display("FAIL rm_post_upd: got %b want 00000001", reg_update); end
        total++; if (reg_q !== 64'h12) begin bad++; $display("FAIL rm_post_regs: got %h want 12", reg_q); end
    endtask

    initial begin
        Reset = 1'b1;
        M2P_MessageBus = 8'h00;
        test_reset();
        test_commit_read();
        test_ordering();
        test_overflow();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
